// File: rtl/sequenciador_posicao.sv
// Position sequencer feeding controle_servo: sweeps posicao 01-10-11-10-01... at a fixed
// interval, with start/stop (ligar), pause (pausa) and a one-cycle mudou strobe per step.
module sequenciador_posicao #(
    parameter int M_INTERVALO = 50_000_000,
    parameter int N_INTERVALO = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pausa,
    output logic [1:0] posicao,
    output logic       sentido,
    output logic       mudou,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        INICIAL = 2'b00,
        ESPERA  = 2'b01,
        PASSO   = 2'b10,
        PAUSADO = 2'b11
    } estado_t;

    // ESPERA counts 0..M-2 and PASSO takes one cycle, so steps land exactly M cycles apart.
    localparam logic [N_INTERVALO-1:0] LIMITE = N_INTERVALO'(M_INTERVALO - 2);
    localparam logic [N_INTERVALO-1:0] UM     = N_INTERVALO'(1);

    estado_t                estado_q,   estado_d;
    logic [1:0]             posicao_q,  posicao_d;
    logic                   sentido_q,  sentido_d;
    logic                   mudou_q,    mudou_d;
    logic [N_INTERVALO-1:0] contador_q, contador_d;

    logic subir;

    // Ping-pong rule: turn around at 11 going up and at 01 going down.
    assign subir = (sentido_q && (posicao_q != 2'b11)) ||
                   (!sentido_q && (posicao_q == 2'b01));

    always_comb begin
        estado_d   = estado_q;
        posicao_d  = posicao_q;
        sentido_d  = sentido_q;
        contador_d = contador_q;
        mudou_d    = 1'b0;

        case (estado_q)
            INICIAL: begin
                posicao_d  = 2'b00;
                sentido_d  = 1'b1;
                contador_d = '0;
                if (ligar) begin
                    estado_d  = ESPERA;
                    posicao_d = 2'b01;
                    mudou_d   = 1'b1;
                end
            end

            ESPERA: begin
                if (!ligar) begin
                    estado_d   = INICIAL;
                    posicao_d  = 2'b00;
                    sentido_d  = 1'b1;
                    contador_d = '0;
                end else if (pausa) begin
                    estado_d = PAUSADO;
                end else if (contador_q == LIMITE) begin
                    estado_d   = PASSO;
                    contador_d = '0;
                end else begin
                    contador_d = contador_q + UM;
                end
            end

            PASSO: begin
                if (!ligar) begin
                    estado_d   = INICIAL;
                    posicao_d  = 2'b00;
                    sentido_d  = 1'b1;
                    contador_d = '0;
                end else begin
                    estado_d = ESPERA;
                    mudou_d  = 1'b1;
                    if (subir) begin
                        posicao_d = posicao_q + 2'd1;
                        sentido_d = 1'b1;
                    end else begin
                        posicao_d = posicao_q - 2'd1;
                        sentido_d = 1'b0;
                    end
                end
            end

            PAUSADO: begin
                if (!ligar) begin
                    estado_d   = INICIAL;
                    posicao_d  = 2'b00;
                    sentido_d  = 1'b1;
                    contador_d = '0;
                end else if (!pausa) begin
                    estado_d = ESPERA;
                end
            end

            default: begin
                estado_d   = INICIAL;
                posicao_d  = 2'b00;
                sentido_d  = 1'b1;
                contador_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            posicao_q  <= 2'b00;
            sentido_q  <= 1'b1;
            mudou_q    <= 1'b0;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            posicao_q  <= posicao_d;
            sentido_q  <= sentido_d;
            mudou_q    <= mudou_d;
            contador_q <= contador_d;
        end
    end

    assign posicao   = posicao_q;
    assign sentido   = sentido_q;
    assign mudou     = mudou_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_posicao.sv
// Directed bench for sequenciador_posicao with a short interval (M_INTERVALO = 5):
// reset, sweep order, pause stretch, stop from each state and reset mid-sweep.
module tb_sequenciador_posicao;

    localparam logic [1:0] S_INICIAL = 2'b00;
    localparam logic [1:0] S_ESPERA  = 2'b01;
    localparam logic [1:0] S_PASSO   = 2'b10;
    localparam logic [1:0] S_PAUSADO = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       pausa = 1'b0;
    logic [1:0] posicao;
    logic       sentido;
    logic       mudou;
    logic [1:0] db_estado;

    int errors = 0;
    int checks = 0;

    logic [1:0] posTab  [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2};
    logic       sentTab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    sequenciador_posicao #(
        .M_INTERVALO(5),
        .N_INTERVALO(3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ligar    (ligar),
        .pausa    (pausa),
        .posicao  (posicao),
        .sentido  (sentido),
        .mudou    (mudou),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after an edge and outputs are read at the same point.
    task automatic applyStimulus(input logic r, input logic l, input logic p, input int n);
        reset = r;
        ligar = l;
        pausa = p;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] expPos, input logic expSent,
                               input logic expMudou, input logic [1:0] expEst);
        checks++;
        assert (posicao === expPos) else begin
            errors++;
            $error("[TB] FAIL %s posicao: got %b expected %b", tag, posicao, expPos);
        end
        checks++;
        assert (sentido === expSent) else begin
            errors++;
            $error("[TB] FAIL %s sentido: got %b expected %b", tag, sentido, expSent);
        end
        checks++;
        assert (mudou === expMudou) else begin
            errors++;
            $error("[TB] FAIL %s mudou: got %b expected %b", tag, mudou, expMudou);
        end
        checks++;
        assert (db_estado === expEst) else begin
            errors++;
            $error("[TB] FAIL %s db_estado: got %b expected %b", tag, db_estado, expEst);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("reset", 2'd0, 1'b1, 1'b0, S_INICIAL);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            checkOutput($sformatf("reset hold %0d", i), 2'd0, 1'b1, 1'b0, S_INICIAL);
        end

        // Offset t after start: a new position every 5 cycles, PASSO in the cycle before it.
        for (int t = 1; t <= 26; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            checkOutput($sformatf("sweep t=%0d", t), posTab[(t-1)/5], sentTab[(t-1)/5],
                        ((t-1)%5) == 0, (((t-1)%5) == 4) ? S_PASSO : S_ESPERA);
        end

        // Pause sampled at edges 28..37 after the step at 26; next step due at 42.
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("pre-pause t=27", 2'd2, 1'b1, 1'b0, S_ESPERA);
        for (int t = 28; t <= 37; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1);
            checkOutput($sformatf("paused t=%0d", t), 2'd2, 1'b1, 1'b0, S_PAUSADO);
        end
        for (int t = 38; t <= 40; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            checkOutput($sformatf("resume t=%0d", t), 2'd2, 1'b1, 1'b0, S_ESPERA);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("resume t=41", 2'd2, 1'b1, 1'b0, S_PASSO);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("step after pause t=42", 2'd3, 1'b1, 1'b1, S_ESPERA);
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        checkOutput("passo t=46", 2'd3, 1'b1, 1'b0, S_PASSO);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("turn down t=47", 2'd2, 1'b0, 1'b1, S_ESPERA);

        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("stop in espera", 2'd0, 1'b1, 1'b0, S_INICIAL);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        checkOutput("stopped hold", 2'd0, 1'b1, 1'b0, S_INICIAL);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("restart 1", 2'd1, 1'b1, 1'b1, S_ESPERA);

        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        checkOutput("reach passo", 2'd1, 1'b1, 1'b0, S_PASSO);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("stop in passo", 2'd0, 1'b1, 1'b0, S_INICIAL);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("restart 2", 2'd1, 1'b1, 1'b1, S_ESPERA);

        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("enter pausado", 2'd1, 1'b1, 1'b0, S_PAUSADO);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("stop in pausado", 2'd0, 1'b1, 1'b0, S_INICIAL);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("restart ignores pausa", 2'd1, 1'b1, 1'b1, S_ESPERA);

        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkOutput("reach 11", 2'd3, 1'b1, 1'b1, S_ESPERA);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("reset mid-sweep", 2'd0, 1'b1, 1'b0, S_INICIAL);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("restart after reset", 2'd1, 1'b1, 1'b1, S_ESPERA);

        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("pause before reset", 2'd1, 1'b1, 1'b0, S_PAUSADO);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("reset in pausado", 2'd0, 1'b1, 1'b0, S_INICIAL);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("restart after reset 2", 2'd1, 1'b1, 1'b1, S_ESPERA);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("single mudou", 2'd1, 1'b1, 1'b0, S_ESPERA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequenciador_posicao.md
# sequenciador_posicao

- Upstream stage of `controle_servo`.
- Generates the 2-bit `posicao` command that sweeps the servo back and forth (ping-pong) through its three active positions at a fixed, parameterised interval.
- Supports start/stop (`ligar`) and pause (`pausa`).
- Emits a one-cycle `mudou` strobe on each position change, so later stages (e.g. a distance measurement) can synchronise to servo movement.

## Interface
- `M_INTERVALO`, default 50_000_000: clock cycles between consecutive position changes (1 s at 50 MHz). Must be ≥ 3.
- `N_INTERVALO`, default 26: counter width. Must satisfy 2^N_INTERVALO ≥ M_INTERVALO.

Ports:
- `clock`  in  1  system clock, 50 MHz, rising edge
- `reset`  in  1  synchronous, active-high
- `ligar`  in  1  level; 1 = sweep enabled, 0 = parked at position 00
- `pausa`  in  1  level; 1 = freeze position and interval count while sweeping
- `posicao`  out  2  position command, connects to `controle_servo.posicao`
- `sentido`  out  1  direction of the most recent step (1 = increasing)
- `mudou`  out  1  one-cycle strobe; `posicao` has just changed to an active value
- `db_estado`  out  2  current FSM state, for debug

## Operation
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Internal interval counter `contador` is N_INTERVALO bits.

FSM states:
- INICIAL = 00
- ESPERA = 01
- PASSO = 10
- PAUSADO = 11

Reset (and power-up values):
- state = INICIAL, `posicao` = 00, `sentido` = 1, `mudou` = 0, `contador` = 0.

INICIAL:
- Holds `posicao` = 00, so `controle_servo` produces no pulse.
- If `ligar` = 1: go to ESPERA and, on the same edge, set `posicao` ← 01, `sentido` ← 1, `contador` ← 0, `mudou` ← 1.
- `pausa` is ignored in this state.

ESPERA, evaluated in this priority order:
1. `ligar` = 0 → INICIAL.
2. `pausa` = 1 → PAUSADO, with `contador` held.
3. `contador` = M_INTERVALO−2 → PASSO, with `contador` ← 0.
4. Otherwise `contador` ← `contador` + 1.

PASSO (exactly one cycle):
- If `ligar` = 0 → INICIAL.
- Otherwise update `posicao`, set `mudou` ← 1, and return to ESPERA.
- `pausa` is not sampled in PASSO; a pending pause takes effect in the following ESPERA cycle.

PAUSADO:
- `ligar` = 0 → INICIAL.
- `pausa` = 0 → ESPERA; counting resumes from the held `contador` value.
- Otherwise hold `posicao`, `sentido` and `contador`.

Step rule, applied in PASSO:
- Step up when (`sentido` = 1 and `posicao` ≠ 11) or (`sentido` = 0 and `posicao` = 01): `posicao` ← `posicao` + 1, `sentido` ← 1.
- In all other cases step down: `posicao` ← `posicao` − 1, `sentido` ← 0.
- Resulting sequence from start: 01, 10, 11, 10, 01, 10, 11, …
- `posicao` never takes the value 00 while sweeping.

Any transition into INICIAL:
- `posicao` ← 00, `sentido` ← 1, `contador` ← 0, `mudou` ← 0.

`mudou`:
- High only in the cycle immediately after an edge that loaded an active position (start or step).
- Low in every other cycle.
- Never high for two consecutive cycles.

## Timing
- `ligar` rising, sampled at edge k:
  - `posicao` = 01 and `mudou` = 1 after edge k.
  - The following position changes are visible after edges k+M, k+2M, … (M = M_INTERVALO), each with a coincident one-cycle `mudou` pulse.
- `ligar` = 0 sampled at edge j, in any state: `posicao` = 00 and `mudou` = 0 after edge j.
- Pause:
  - `pausa` = 1 asserted for P cycles during ESPERA extends the current interval by P+1 cycles: one cycle to enter PAUSADO and one to leave it, minus the cycle that is held rather than counted.
  - The bench checks total elapsed cycles = M + P + 1.
- `reset` has priority over every input and takes effect at the sampling edge, including mid-PASSO and in PAUSADO.
- After reset with `ligar` still high, the sweep restarts at 01 on the next edge.

## Test plan
- **Reset:** `reset` = 1 for 1 cycle with `ligar` = 0 → `posicao` = 00, `sentido` = 1, `mudou` = 0, `db_estado` = 00; outputs hold for 20 cycles.
- **Sweep (M_INTERVALO = 5):** `ligar` = 1 → `posicao` 01, 10, 11, 10, 01, 10 at cycles 1, 6, 11, 16, 21, 26 after start; `sentido` 1, 1, 1, 0, 0, 1; exactly one `mudou` pulse at each change.
- **Pause (M = 5):** `pausa` = 1 for 10 cycles starting 2 cycles after a step → `posicao` frozen; `db_estado` = 11; next step arrives 16 cycles after the previous one (M + P + 1).
- **Stop:** `ligar` dropped while in ESPERA, PASSO and PAUSADO (three runs) → `posicao` = 00 one edge later, no `mudou`; re-raising `ligar` restarts at 01 with `sentido` = 1.
- **Reset mid-sweep:** `reset` pulsed at `posicao` = 11 with `ligar` = 1 → 00 at that edge, 01 with `mudou` = 1 on the next edge.
- **Integration with `controle_servo` (M = 50_000_000):** `controle` pulse widths of 1 ms, 1.5 ms, 2 ms, 1.5 ms appear in successive 1 s windows.
